// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID-stage issue scoreboard.
package cpu_pkg;
    localparam int SB_NREG  = 32;
    localparam int SB_CNT_W = 2;
    localparam int SB_TOT_W = 7;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// One per-register in-flight write counter: saturating up/down with two independent decrements.
module sb_counter
    import cpu_pkg::*;
#(
    parameter int W = SB_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec_a,
    input  logic         dec_b,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         underflow
);
    localparam logic [W+1:0] MAX_EXT = {2'b00, {W{1'b1}}};

    logic [W+1:0] up;
    logic [W+1:0] down;
    logic [W+1:0] diff;
    logic [W-1:0] count_next;

    // Wider intermediate so a double decrement below zero is detected instead of wrapping.
    always_comb begin
        up         = {2'b00, count} + {{(W+1){1'b0}}, inc};
        down       = {{(W+1){1'b0}}, dec_a} + {{(W+1){1'b0}}, dec_b};
        diff       = up - down;
        underflow  = down > up;
        count_next = count;
        if (underflow) begin
            count_next = '0;
        end else if (diff > MAX_EXT) begin
            count_next = {W{1'b1}};
        end else begin
            count_next = diff[W-1:0];
        end
    end

    assign at_max = (count == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end
endmodule

// File: rtl/id_issue_scoreboard.sv
// ID-stage issue controller: tracks in-flight GPR writes and stalls ID on RAW,
// counter saturation or a full ID->EX FIFO.
module id_issue_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W,
    parameter int TOT_W = SB_TOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_rw,
    input  logic             id_flush,
    input  logic             fifo_full,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rw,
    input  logic             kill_valid,
    input  logic [4:0]       kill_rw,
    output logic             issue,
    output logic             stall,
    output logic [TOT_W-1:0] outstanding,
    output logic             err
);
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            at_max;
    logic [NREG-1:0]            underflow;

    logic rs_haz;
    logic rt_haz;
    logic sat_haz;
    logic hold;

    // r0 is hardwired zero, so it has no counter and can never hazard or underflow.
    assign cnt[0]       = '0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc_r;
        logic wb_r;
        logic kill_r;

        assign inc_r  = issue && id_reg_write && (id_rw == 5'(r));
        assign wb_r   = wb_valid && (wb_rw == 5'(r));
        assign kill_r = kill_valid && (kill_rw == 5'(r));

        sb_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_r),
            .dec_a     (wb_r),
            .dec_b     (kill_r),
            .count     (cnt[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    // A last pending writer retiring this cycle writes the GPR before the ID read, so it is not a hazard.
    always_comb begin
        rs_haz = id_use_rs && (id_rs != 5'd0) && (cnt[id_rs] != '0)
                 && !(wb_valid && (wb_rw == id_rs) && (cnt[id_rs] == CNT_W'(1)));
        rt_haz = id_use_rt && (id_rt != 5'd0) && (cnt[id_rt] != '0)
                 && !(wb_valid && (wb_rw == id_rt) && (cnt[id_rt] == CNT_W'(1)));
        sat_haz = id_reg_write && (id_rw != 5'd0) && at_max[id_rw]
                  && !((wb_valid && (wb_rw == id_rw)) || (kill_valid && (kill_rw == id_rw)));
        hold  = id_valid && !id_flush && (rs_haz || rt_haz || sat_haz || fifo_full);
        stall = !rst || hold;
        issue = rst && id_valid && !id_flush && !hold;
    end

    always_comb begin
        outstanding = '0;
        for (int i = 1; i < NREG; i++) begin
            outstanding = outstanding + TOT_W'(cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (|underflow) begin
            err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Scenario and randomized bench for id_issue_scoreboard against a per-register count model.
module tb_id_issue_scoreboard;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_reg_write;
    logic [4:0] id_rw;
    logic       id_flush;
    logic       fifo_full;
    logic       wb_valid;
    logic [4:0] wb_rw;
    logic       kill_valid;
    logic [4:0] kill_rw;
    logic       issue;
    logic       stall;
    logic [6:0] outstanding;
    logic       err;

    int checks = 0;
    int errors = 0;
    int m[32];
    bit m_err;
    bit exp_issue;
    bit exp_stall;

    always #5 clk = ~clk;

    id_issue_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_reg_write (id_reg_write),
        .id_rw        (id_rw),
        .id_flush     (id_flush),
        .fifo_full    (fifo_full),
        .wb_valid     (wb_valid),
        .wb_rw        (wb_rw),
        .kill_valid   (kill_valid),
        .kill_rw      (kill_rw),
        .issue        (issue),
        .stall        (stall),
        .outstanding  (outstanding),
        .err          (err)
    );

    task automatic drive_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_reg_write = 0; id_rw = 0; id_flush = 0; fifo_full = 0;
        wb_valid = 0; wb_rw = 0; kill_valid = 0; kill_rw = 0;
    endtask

    function automatic bit src_hazard(bit use_s, logic [4:0] src);
        int r = int'(src);
        if (!use_s || r == 0 || m[r] == 0) return 0;
        if (wb_valid && wb_rw == src && m[r] == 1) return 0;
        return 1;
    endfunction

    task automatic calc();
        bit sat;
        bit hold;
        sat = id_reg_write && id_rw != 0 && m[id_rw] == 3
              && !((wb_valid && wb_rw == id_rw) || (kill_valid && kill_rw == id_rw));
        hold = id_valid && !id_flush
               && (src_hazard(id_use_rs, id_rs) || src_hazard(id_use_rt, id_rt) || sat || fifo_full);
        if (!rst) begin
            exp_stall = 1; exp_issue = 0;
        end else begin
            exp_stall = hold; exp_issue = id_valid && !id_flush && !hold;
        end
    endtask

    function automatic int m_sum();
        int s = 0;
        for (int r = 1; r < 32; r++) s += m[r];
        return s;
    endfunction

    task automatic tick();
        int d;
        calc();
        @(posedge clk);
        if (!rst) begin
            for (int r = 0; r < 32; r++) m[r] = 0;
            m_err = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                d = m[r];
                if (exp_issue && id_reg_write && id_rw == r) d++;
                if (wb_valid && wb_rw == r) d--;
                if (kill_valid && kill_rw == r) d--;
                if (d < 0) begin d = 0; m_err = 1; end
                if (d > 3) d = 3;
                m[r] = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0; id_valid = 1; id_rs = 5; id_use_rs = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || issue !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_forced: stall=%b issue=%b, want stall=1 issue=0", stall, issue);
            end
            tick();
        end
        rst = 1;
        #1;
        checks++;
        if (outstanding !== 7'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: outstanding=%0d err=%b, want 0 0", outstanding, err);
        end
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_issue: issue=%b stall=%b, want 1 0", issue, stall);
        end
        tick();
    endtask

    task automatic test_raw();
        drive_idle();
        id_valid = 1; id_reg_write = 1; id_rw = 8;
        #1;
        checks++;
        if (issue !== 1'b1) begin
            errors++;
            $display("[TB] FAIL raw_writer: issue=%b, want 1", issue);
        end
        tick();
        id_reg_write = 0; id_rs = 8; id_use_rs = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0 || outstanding !== 7'd1) begin
            errors++;
            $display("[TB] FAIL raw_stall: stall=%b issue=%b outstanding=%0d, want 1 0 1", stall, issue, outstanding);
        end
        tick();
        wb_valid = 1; wb_rw = 8;
        #1;
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_wb_bypass: issue=%b stall=%b, want 1 0", issue, stall);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd0) begin
            errors++;
            $display("[TB] FAIL raw_retired: outstanding=%0d, want 0", outstanding);
        end
    endtask

    task automatic test_saturation();
        drive_idle();
        id_valid = 1; id_reg_write = 1; id_rw = 3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_fill%0d: issue=%b, want 1", i, issue);
            end
            tick();
        end
        #1;
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0 || outstanding !== 7'd3) begin
            errors++;
            $display("[TB] FAIL sat_stall: stall=%b issue=%b outstanding=%0d, want 1 0 3", stall, issue, outstanding);
        end
        tick();
        wb_valid = 1; wb_rw = 3;
        #1;
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_wb_release: issue=%b stall=%b, want 1 0", issue, stall);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd3 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_hold3: outstanding=%0d err=%b, want 3 0", outstanding, err);
        end
        wb_valid = 1; wb_rw = 3;
        repeat (3) tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd0) begin
            errors++;
            $display("[TB] FAIL sat_drain: outstanding=%0d, want 0", outstanding);
        end
    endtask

    task automatic test_r0_flush();
        drive_idle();
        id_valid = 1; id_reg_write = 1; id_rw = 0;
        #1;
        checks++;
        if (issue !== 1'b1) begin
            errors++;
            $display("[TB] FAIL r0_writer_issue: issue=%b, want 1", issue);
        end
        tick();
        drive_idle();
        wb_valid = 1; wb_rw = 0; kill_valid = 1; kill_rw = 0;
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_ignored: outstanding=%0d err=%b, want 0 0", outstanding, err);
        end
        id_valid = 1; id_reg_write = 1; id_rw = 4;
        tick();
        id_rs = 0; id_use_rs = 1; id_rt = 0; id_use_rt = 1; id_reg_write = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || issue !== 1'b1) begin
            errors++;
            $display("[TB] FAIL r0_reader: stall=%b issue=%b, want 0 1", stall, issue);
        end
        tick();
        id_rs = 4; id_reg_write = 1; id_rw = 4; id_flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || issue !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_priority: stall=%b issue=%b, want 0 0", stall, issue);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd1) begin
            errors++;
            $display("[TB] FAIL flush_no_inc: outstanding=%0d, want 1", outstanding);
        end
        wb_valid = 1; wb_rw = 4;
        tick();
        drive_idle();
    endtask

    task automatic test_fifo_full();
        drive_idle();
        id_valid = 1; id_rs = 6; id_use_rs = 1; fifo_full = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifo_full_stall: stall=%b issue=%b, want 1 0", stall, issue);
        end
        tick();
        fifo_full = 0;
        #1;
        checks++;
        if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fifo_release: issue=%b stall=%b, want 1 0", issue, stall);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        drive_idle();
        id_valid = 1; id_reg_write = 1; id_rw = 9;
        repeat (2) tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd2) begin
            errors++;
            $display("[TB] FAIL sim_setup: outstanding=%0d, want 2", outstanding);
        end
        wb_valid = 1; wb_rw = 9; kill_valid = 1; kill_rw = 9;
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sim_double_dec: outstanding=%0d err=%b, want 0 0", outstanding, err);
        end
        kill_valid = 1; kill_rw = 9;
        tick();
        drive_idle();
        #1;
        checks++;
        if (outstanding !== 7'd0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sim_underflow: outstanding=%0d err=%b, want 0 1", outstanding, err);
        end
        tick();
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_random();
        drive_idle();
        rst = 0;
        tick();
        rst = 1;
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) != 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_reg_write = 1'($urandom_range(0, 1));
            id_rw        = 5'($urandom_range(0, 7));
            id_flush     = ($urandom_range(0, 7) == 0);
            fifo_full    = ($urandom_range(0, 7) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_rw        = 5'($urandom_range(0, 7));
            kill_valid   = ($urandom_range(0, 7) == 0);
            kill_rw      = 5'($urandom_range(0, 7));
            #1;
            calc();
            checks++;
            if (stall !== exp_stall || issue !== exp_issue) begin
                errors++;
                $display("[TB] FAIL rand_ctrl[%0d]: stall=%b issue=%b, want %b %b", i, stall, issue, exp_stall, exp_issue);
            end
            checks++;
            if (outstanding !== 7'(m_sum()) || err !== m_err) begin
                errors++;
                $display("[TB] FAIL rand_state[%0d]: outstanding=%0d err=%b, want %0d %b", i, outstanding, err, m_sum(), m_err);
            end
            tick();
        end
        rst = 1;
        drive_idle();
    endtask

    initial begin
        rst = 0;
        drive_idle();
        for (int r = 0; r < 32; r++) m[r] = 0;
        m_err = 0;
        @(negedge clk);
        test_reset();
        test_raw();
        test_saturation();
        test_r0_flush();
        test_fifo_full();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_issue_scoreboard.md
# id_issue_scoreboard

Issue controller for the ID stage of the 5-stage MIPS pipeline. It keeps a per-register count of in-flight writes between ID issue and WB retire or squash. It stalls ID when a source register has an unresolved write, when the destination counter is saturated, or when the ID→EX FIFO is full. It drives the issue/stall signals the ID stage uses to gate its FIFO write and hold IF/ID.

## Interface
Parameters:
- NREG, 32, number of architectural GPRs (r0 never tracked)
- CNT_W, 2, width of each per-register in-flight counter (max 2^CNT_W−1 = 3)
- TOT_W, 7, width of the total outstanding-write count

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  5 each  source register indices
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt
- id_reg_write, id_rw  in  1, 5  instruction writes GPR id_rw
- id_flush  in  1  ID instruction squashed this cycle (ID_FLUSH)
- fifo_full  in  1  ID→EX FIFO cannot accept a write
- wb_valid, wb_rw  in  1, 5  WB writes GPR wb_rw this cycle (retire)
- kill_valid, kill_rw  in  1, 5  an in-flight writer of kill_rw is squashed in EX/MEM (drop without write)
- issue  out  1  instruction accepted this cycle; gates FIFO wen
- stall  out  1  hold PC and IF/ID
- outstanding  out  TOT_W  sum of all counters
- err  out  1  sticky: decrement requested on a zero counter

## Operation
- State: cnt[1..NREG−1] of CNT_W bits, err.
- Source hazard for src ∈ {rs, rt}: use_src && src≠0 && cnt[src]≠0.
  - Exception: wb_valid && wb_rw==src && cnt[src]==1. The GPR writes before the ID read, so this is not a hazard.
  - Assumption: the ID stage handles forwarding from EX/MEM only for values produced before they reach ID. A pending writer still in EX or MEM therefore stalls.
- Saturation hazard: id_reg_write && id_rw≠0 && cnt[id_rw]==max && !(wb or kill decrements id_rw this cycle).
- stall = id_valid && !id_flush && (src hazard || saturation || fifo_full).
- issue = id_valid && !id_flush && !stall.
- Counter update for reg r≠0, net = inc − dec_wb − dec_kill:
  - inc = issue && id_reg_write && id_rw==r.
  - dec_wb = wb_valid && wb_rw==r.
  - dec_kill = kill_valid && kill_rw==r.
  - wb and kill on the same r in the same cycle → decrement by 2.
  - A decrement that would go below 0 clamps at 0 and sets err.
  - Writes to r0 (inc or dec) are ignored and never set err.
- outstanding = Σcnt, registered alongside the counters.

## Timing
- While rst low:
  - At the clock edge: all cnt = 0, err = 0, outstanding = 0.
  - Combinational outputs are forced: issue = 0, stall = 1.
- stall and issue are combinational from current state and inputs, in the same cycle as id_valid.
- Counters, outstanding and err update at the rising edge following the event. A write issued at edge N is visible as a hazard to the next ID instruction in cycle N+1.
- Issue and retire of the same reg in the same cycle: the count is unchanged.
- Retire is honoured while stalled; inc happens only when issue=1.
- id_flush has priority over all hazards: issue = 0, stall = 0, no inc.
- Reset asserted mid-operation discards all in-flight tracking at the next edge. The pipeline flushes under the same reset.

## Structure
- Shared package cpu_pkg holds:
  - localparams SB_NREG, SB_CNT_W.
  - typedef sb_cnt_t = logic [SB_CNT_W-1:0].
- One sub-module, sb_counter: a single saturating up/down counter with inputs inc, dec_a, dec_b. It outputs count, at_max and underflow. It is instantiated NREG−1 times via generate.
- Hazard compare and the outstanding adder tree live in id_issue_scoreboard.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_valid=1 → stall=1, issue=0. After release, outstanding=0, err=0, and an instruction reading rs=5 issues immediately.
- RAW stall: issue write r8. Next cycle, reader rs=8 use_rs=1 → stall=1. Assert wb_valid wb_rw=8 → issue=1 that cycle; cnt[8]=0 afterwards.
- Saturation: issue 3 writers to r3, no retire → cnt[3]=3. A 4th writer to r3 → stall=1. wb_rw=3 that cycle → 4th issues; cnt stays 3.
- Simultaneous: cnt[9]=2, kill_rw=9 and wb_rw=9 in the same cycle → cnt[9]=0, err=0. A further kill_rw=9 → cnt stays 0, err=1 (sticky).
- r0 and flush: writer id_rw=0 → outstanding unchanged. Reader rs=0 never stalls. id_flush=1 with a pending RAW → stall=0, issue=0, no inc.
- FIFO full: fifo_full=1 with no hazards → stall=1, issue=0. Deassert → issue=1 the same cycle.
